// File: rtl/tdp_bram_arb_pkg.sv
// Shared types and the round-robin search helper for the dual-port BRAM arbiter.
package tdp_bram_arb_pkg;

  // Requester ids are sized for the largest supported requester count.
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rsp_slot_t;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod num.
  function automatic logic [ID_W:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    start,
                                            input int                 num);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W:0]   pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = {1'b0, start} + k[ID_W:0];
      if (pos >= num[ID_W:0]) pos = pos - num[ID_W:0];
      if (k < num && !found && valid[pos[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[ID_W-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Picks the first two valid requesters in round-robin order starting at rr_ptr.
module rr_pick2
  import tdp_bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               g0_found_o,
  output logic [ID_W-1:0]    g0_idx_o,
  output logic               g1_found_o,
  output logic [ID_W-1:0]    g1_idx_o
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] masked;
  logic [ID_W:0]      pick0;
  logic [ID_W:0]      pick1;
  logic [ID_W-1:0]    next_start;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid_i;
    pick0                  = rr_pick(valid_ext, rr_ptr_i, NUM_REQ);
    masked                 = valid_ext;
    masked[pick0[ID_W-1:0]] = 1'b0;
    // Everything between rr_ptr and g0 is idle, so scanning on from g0+1 keeps the order.
    next_start = (pick0[ID_W-1:0] == LAST_IDX) ? '0 : pick0[ID_W-1:0] + 1'b1;
    pick1      = rr_pick(masked, next_start, NUM_REQ);
  end

  assign g0_found_o = pick0[ID_W];
  assign g0_idx_o   = pick0[ID_W-1:0];
  assign g1_found_o = pick0[ID_W] & pick1[ID_W];
  assign g1_idx_o   = pick1[ID_W-1:0];

endmodule

// File: rtl/tdp_bram_arbiter.sv
// Shares one true dual-port BRAM among NUM_REQ requesters: two round-robin grants per
// cycle, same-address write collisions deferred, read data routed back to the issuer.
module tdp_bram_arbiter
  import tdp_bram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DWIDTH    = 8,
  parameter int ADDR_W    = 8,
  parameter int READ_SYNC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_single_port,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DWIDTH-1:0] rsp_rdata,
  output logic                      mem_clk_en,
  output logic                      mem_singleportmode,
  output logic                      mem_port_en_0,
  output logic                      mem_wr_en_0,
  output logic [ADDR_W-1:0]         mem_addr_0,
  output logic [DWIDTH-1:0]         mem_wdata_0,
  input  logic [DWIDTH-1:0]         mem_rdata_0,
  output logic                      mem_port_en_1,
  output logic                      mem_wr_en_1,
  output logic [ADDR_W-1:0]         mem_addr_1,
  output logic [DWIDTH-1:0]         mem_wdata_1,
  input  logic [DWIDTH-1:0]         mem_rdata_1,
  output logic [CNT_W-1:0]          conflict_count
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic [ADDR_W-1:0]  addr_arr  [MAX_REQ];
  logic [DWIDTH-1:0]  wdata_arr [MAX_REQ];
  logic [MAX_REQ-1:0] wr_ext;

  logic            g0_found, g1_found;
  logic [ID_W-1:0] g0_idx, g1_idx;
  logic            grant0, grant1, conflict, same_addr, any_wr;
  logic [ID_W-1:0] last_idx;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rsp_slot_t        slot0_q, slot0_d, slot1_q, slot1_d;
  rsp_slot_t        slot0_rsp, slot1_rsp;

  generate
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_real
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DWIDTH +: DWIDTH];
        assign wr_ext[gi]    = req_wr[gi];
      end else begin : g_pad
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign wr_ext[gi]    = 1'b0;
      end
    end
  endgenerate

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i    (req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .g0_found_o (g0_found),
    .g0_idx_o   (g0_idx),
    .g1_found_o (g1_found),
    .g1_idx_o   (g1_idx)
  );

  always_comb begin
    same_addr = (addr_arr[g0_idx] == addr_arr[g1_idx]);
    any_wr    = wr_ext[g0_idx] | wr_ext[g1_idx];
    grant0    = !rst && g0_found;
    // Single-port drops take precedence and are not counted as conflicts.
    conflict  = grant0 && g1_found && !cfg_single_port && same_addr && any_wr;
    grant1    = grant0 && g1_found && !cfg_single_port && !(same_addr && any_wr);
    last_idx  = grant1 ? g1_idx : g0_idx;

    rr_ptr_d = rr_ptr_q;
    if (grant0) rr_ptr_d = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;

    cnt_d = cnt_q;
    if (conflict && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    slot0_d.valid = grant0 && !wr_ext[g0_idx];
    slot0_d.id    = g0_idx;
    slot1_d.valid = grant1 && !wr_ext[g1_idx];
    slot1_d.id    = g1_idx;
  end

  assign mem_clk_en         = !rst;
  assign mem_singleportmode = cfg_single_port;
  assign mem_port_en_0      = grant0;
  assign mem_wr_en_0        = grant0 & wr_ext[g0_idx];
  assign mem_addr_0         = addr_arr[g0_idx];
  assign mem_wdata_0        = wdata_arr[g0_idx];
  assign mem_port_en_1      = grant1;
  assign mem_wr_en_1        = grant1 & wr_ext[g1_idx];
  assign mem_addr_1         = addr_arr[g1_idx];
  assign mem_wdata_1        = wdata_arr[g1_idx];
  assign conflict_count     = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      slot0_q  <= '0;
      slot1_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
    end
  end

  // Response tags line up with the RAM's read latency.
  generate
    if (READ_SYNC != 0) begin : g_sync
      assign slot0_rsp = slot0_q;
      assign slot1_rsp = slot1_q;
    end else begin : g_comb
      assign slot0_rsp = slot0_d;
      assign slot1_rsp = slot1_d;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      logic hit0, hit1;
      assign hit0 = slot0_rsp.valid && (slot0_rsp.id == ID_W'(gi));
      assign hit1 = slot1_rsp.valid && (slot1_rsp.id == ID_W'(gi));
      assign req_ready[gi] = (grant0 && g0_idx == ID_W'(gi)) || (grant1 && g1_idx == ID_W'(gi));
      assign rsp_valid[gi] = !rst && (hit0 || hit1);
      assign rsp_rdata[gi*DWIDTH +: DWIDTH] = rst  ? '0 :
                                              hit0 ? mem_rdata_0 :
                                              hit1 ? mem_rdata_1 : '0;
    end
  endgenerate

endmodule

// File: tb/tb_tdp_bram_arbiter.sv
// Directed bench for tdp_bram_arbiter with a BRAM model and a per-requester response scoreboard.
module tb_tdp_bram_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_single_port;
  logic [NR-1:0] req_valid, req_ready, req_wr, rsp_valid;
  logic [NR*8-1:0] req_addr, req_wdata, rsp_rdata;
  logic          mem_clk_en, mem_singleportmode;
  logic          mem_port_en_0, mem_wr_en_0, mem_port_en_1, mem_wr_en_1;
  logic [7:0]    mem_addr_0, mem_wdata_0, mem_rdata_0;
  logic [7:0]    mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [15:0]   conflict_count;

  logic [7:0] ram [256];
  logic [7:0] exp_q [NR][$];
  logic [7:0] exp_data [NR];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdp_bram_arbiter dut (
    .clk(clk), .rst(rst), .cfg_single_port(cfg_single_port),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_clk_en(mem_clk_en), .mem_singleportmode(mem_singleportmode),
    .mem_port_en_0(mem_port_en_0), .mem_wr_en_0(mem_wr_en_0),
    .mem_addr_0(mem_addr_0), .mem_wdata_0(mem_wdata_0), .mem_rdata_0(mem_rdata_0),
    .mem_port_en_1(mem_port_en_1), .mem_wr_en_1(mem_wr_en_1),
    .mem_addr_1(mem_addr_1), .mem_wdata_1(mem_wdata_1), .mem_rdata_1(mem_rdata_1),
    .conflict_count(conflict_count)
  );

  // Registered-read true dual-port RAM model
  always @(posedge clk) begin
    if (mem_clk_en) begin
      if (mem_port_en_0) begin
        if (mem_wr_en_0) ram[mem_addr_0] <= mem_wdata_0;
        mem_rdata_0 <= ram[mem_addr_0];
      end
      if (mem_port_en_1) begin
        if (mem_wr_en_1) ram[mem_addr_1] <= mem_wdata_1;
        mem_rdata_1 <= ram[mem_addr_1];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response appears
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rsp_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: requester %0d got %0h expected no response", i, rsp_rdata[i*8 +: 8]);
        end else begin
          logic [7:0] e;
          e = exp_q[i].pop_front();
          $display("rsp req%0d data=%0h exp=%0h", i, rsp_rdata[i*8 +: 8], e);
          check($sformatf("rsp_data_req%0d", i), 32'(rsp_rdata[i*8 +: 8]), 32'(e));
        end
      end else begin
        check($sformatf("rsp_idle_lane%0d", i), 32'(rsp_rdata[i*8 +: 8]), 32'h0);
      end
    end
  end

  task automatic set_req(input int i, input logic wr, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] exp_rd);
    req_valid[i]        = 1'b1;
    req_wr[i]           = wr;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*8 +: 8] = wd;
    exp_data[i]         = exp_rd;
  endtask

  task automatic do_cycle(input string name, input logic [3:0] exp_ready,
                          input logic exp_pe0, input logic exp_pe1, input bit keep);
    logic [3:0] acc;
    @(negedge clk);
    $display("cycle %s ready=%b pe0=%b pe1=%b", name, req_ready, mem_port_en_0, mem_port_en_1);
    check({name, "_ready"}, 32'(req_ready), 32'(exp_ready));
    check({name, "_pe0"}, 32'(mem_port_en_0), 32'(exp_pe0));
    check({name, "_pe1"}, 32'(mem_port_en_1), 32'(exp_pe1));
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i] && !req_wr[i]) exp_q[i].push_back(exp_data[i]);
    if (!keep) req_valid = req_valid & ~acc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_single_port = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NR; i++) exp_data[i] = 8'h00;

    // Reset with every requester writing 0x30+i = 0x11*(i+1)
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'h30 + i), 8'(8'h11 * (i + 1)), 8'h00);
    repeat (2) begin
      @(negedge clk);
      $display("reset ready=%b clk_en=%b cnt=%0d", req_ready, mem_clk_en, conflict_count);
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_pe0", 32'(mem_port_en_0), 32'h0);
      check("rst_pe1", 32'(mem_port_en_1), 32'h0);
      check("rst_clk_en", 32'(mem_clk_en), 32'h0);
      check("rst_cnt", 32'(conflict_count), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    @(posedge clk); #1; rst = 1'b0;
    do_cycle("init01", 4'b0011, 1'b1, 1'b1, 1'b0);
    check("clk_en_on", 32'(mem_clk_en), 32'h1);
    check("spm_off", 32'(mem_singleportmode), 32'h0);
    do_cycle("init23", 4'b1100, 1'b1, 1'b1, 1'b0);

    // Write then read-back through a different requester
    set_req(0, 1'b1, 8'h10, 8'hD0, 8'h00);
    do_cycle("wr10", 4'b0001, 1'b1, 1'b0, 1'b0);
    set_req(1, 1'b0, 8'h10, 8'h00, 8'hD0);
    do_cycle("rd10", 4'b0010, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rd10_latency", 32'(rsp_valid), 32'b0010);
    @(posedge clk); #1;
    set_req(3, 1'b0, 8'h10, 8'h00, 8'hD0);
    do_cycle("rd10_r3", 4'b1000, 1'b1, 1'b0, 1'b0);

    // Write-write collision on 0x20 with rr_ptr = 0
    set_req(0, 1'b1, 8'h20, 8'hA5, 8'h00);
    set_req(1, 1'b1, 8'h20, 8'h5A, 8'h00);
    @(negedge clk);
    $display("cycle ww1 ready=%b pe1=%b addr0=%0h", req_ready, mem_port_en_1, mem_addr_0);
    check("ww1_ready", 32'(req_ready), 32'b0001);
    check("ww1_pe1", 32'(mem_port_en_1), 32'h0);
    check("ww1_addr0", 32'(mem_addr_0), 32'h20);
    check("ww1_wdata0", 32'(mem_wdata_0), 32'hA5);
    check("ww1_wr0", 32'(mem_wr_en_0), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("ww1_cnt", 32'(conflict_count), 32'h1);
    do_cycle("ww2", 4'b0010, 1'b1, 1'b0, 1'b0);
    check("ww2_cnt", 32'(conflict_count), 32'h1);
    set_req(2, 1'b0, 8'h20, 8'h00, 8'h5A);
    do_cycle("rd20", 4'b0100, 1'b1, 1'b0, 1'b0);

    // Two reads of the same address share the cycle
    set_req(2, 1'b0, 8'h10, 8'h00, 8'hD0);
    set_req(3, 1'b0, 8'h10, 8'h00, 8'hD0);
    do_cycle("rr10", 4'b1100, 1'b1, 1'b1, 1'b0);
    check("rr10_cnt", 32'(conflict_count), 32'h1);
    set_req(3, 1'b0, 8'h20, 8'h00, 8'h5A);
    do_cycle("rd20_r3", 4'b1000, 1'b1, 1'b0, 1'b0);

    // All four stream reads: pairs alternate (0,1), (2,3)
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(8'h30 + i), 8'h00, 8'(8'h11 * (i + 1)));
    do_cycle("fair_a", 4'b0011, 1'b1, 1'b1, 1'b1);
    do_cycle("fair_b", 4'b1100, 1'b1, 1'b1, 1'b1);
    do_cycle("fair_c", 4'b0011, 1'b1, 1'b1, 1'b1);
    do_cycle("fair_d", 4'b1100, 1'b1, 1'b1, 1'b0);

    // Single-port mode
    cfg_single_port = 1'b1;
    set_req(0, 1'b0, 8'h30, 8'h00, 8'h11);
    set_req(1, 1'b0, 8'h31, 8'h00, 8'h22);
    do_cycle("sp0", 4'b0001, 1'b1, 1'b0, 1'b0);
    check("spm_on", 32'(mem_singleportmode), 32'h1);
    do_cycle("sp1", 4'b0010, 1'b1, 1'b0, 1'b0);
    check("sp_cnt", 32'(conflict_count), 32'h1);
    cfg_single_port = 1'b0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < NR; i++)
      check($sformatf("pending_req%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
